// File: rtl/bubsys_sdram_arbiter_if.sv
// SDRAM controller request bus shared by the arbiter and controller.
// One request is held until acked; completion is a single-cycle strobe.
interface bubsys_sdram_arbiter_if #(
  parameter int AW = 24
);
  logic          o_MEM_RQ;
  logic          o_MEM_WE;
  logic [AW-1:0] o_MEM_ADDR;
  logic [15:0]   o_MEM_DIN;
  logic          i_MEM_ACK;
  logic          i_MEM_RDY;
  logic [15:0]   i_MEM_DOUT;

  modport master (
    output o_MEM_RQ,
    output o_MEM_WE,
    output o_MEM_ADDR,
    output o_MEM_DIN,
    input  i_MEM_ACK,
    input  i_MEM_RDY,
    input  i_MEM_DOUT
  );

  modport slave (
    input  o_MEM_RQ,
    input  o_MEM_WE,
    input  o_MEM_ADDR,
    input  o_MEM_DIN,
    output i_MEM_ACK,
    output i_MEM_RDY,
    output i_MEM_DOUT
  );
endinterface

// File: rtl/bubsys_sdram_arbiter.sv
// Bubble System SDRAM arbiter: packs ioctl download bytes into word
// writes and serves CPU/sound ROM reads, one transaction in flight.
module bubsys_sdram_arbiter #(
  parameter int AW         = 24,
  parameter int STARVE_MAX = 8
) (
  input  logic          i_EMU_MCLK,
  input  logic          i_EMU_RST_n,
  input  logic          i_DL_EN,
  input  logic          i_DL_WR,
  input  logic [26:0]   i_DL_ADDR,
  input  logic [7:0]    i_DL_DATA,
  output logic          o_DL_WAIT,
  input  logic          i_CPU_RQ,
  input  logic          i_SND_RQ,
  input  logic [AW-1:0] i_CPU_ADDR,
  input  logic [AW-1:0] i_SND_ADDR,
  output logic [15:0]   o_CPU_DATA,
  output logic [15:0]   o_SND_DATA,
  output logic          o_CPU_RDY,
  output logic          o_SND_RDY,
  bubsys_sdram_arbiter_if.master mem
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_DL, OWN_CPU, OWN_SND
  } own_t;

  state_t        state;
  own_t          owner;
  logic [7:0]    lo_byte;
  logic [AW-1:0] lo_addr;
  logic          half;
  logic          pend;
  logic [AW-1:0] w_addr;
  logic [15:0]   w_data;
  logic [3:0]    starve;

  logic dl_even;
  logic dl_odd;
  logic flush;
  logic idle;
  logic grant_snd;
  logic grant_cpu;
  logic mem_done;
  logic unused_dl_addr;

  assign unused_dl_addr = ^i_DL_ADDR[26:AW+1];

  assign idle    = (state == IDLE);
  assign dl_even = i_DL_WR & ~i_DL_ADDR[0];
  assign dl_odd  = i_DL_WR & i_DL_ADDR[0]
                 & ~o_DL_WAIT;
  // Trailing even byte: wait for any write in
  // flight, then push it out zero-padded.
  assign flush   = ~i_DL_EN & half & ~pend
                 & ~o_DL_WAIT & ~i_DL_WR;

  assign grant_snd = idle & ~pend & ~i_DL_EN
                   & i_SND_RQ
                   & ((starve == SMAX) | ~i_CPU_RQ);
  assign grant_cpu = idle & ~pend & ~i_DL_EN
                   & i_CPU_RQ & ~grant_snd;

  assign mem_done =
    ((state == ISSUE) & mem.i_MEM_ACK
                      & mem.i_MEM_RDY) |
    ((state == WAIT)  & mem.i_MEM_RDY);

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      state          <= IDLE;
      owner          <= OWN_DL;
      lo_byte        <= '0;
      lo_addr        <= '0;
      half           <= 1'b0;
      pend           <= 1'b0;
      w_addr         <= '0;
      w_data         <= '0;
      starve         <= '0;
      o_DL_WAIT      <= 1'b0;
      o_CPU_DATA     <= '0;
      o_SND_DATA     <= '0;
      o_CPU_RDY      <= 1'b0;
      o_SND_RDY      <= 1'b0;
      mem.o_MEM_RQ   <= 1'b0;
      mem.o_MEM_WE   <= 1'b0;
      mem.o_MEM_ADDR <= '0;
      mem.o_MEM_DIN  <= '0;
    end else begin
      o_CPU_RDY <= 1'b0;
      o_SND_RDY <= 1'b0;

      unique case (1'b1)
        dl_even: begin
          lo_byte <= i_DL_DATA;
          lo_addr <= i_DL_ADDR[AW:1];
          half    <= 1'b1;
        end
        dl_odd: begin
          w_data    <= {i_DL_DATA, lo_byte};
          w_addr    <= i_DL_ADDR[AW:1];
          pend      <= 1'b1;
          half      <= 1'b0;
          o_DL_WAIT <= 1'b1;
        end
        flush: begin
          w_data    <= {8'h00, lo_byte};
          w_addr    <= lo_addr;
          pend      <= 1'b1;
          half      <= 1'b0;
          o_DL_WAIT <= 1'b1;
        end
        default: ;
      endcase

      if (!i_SND_RQ || grant_snd)
        starve <= '0;
      else if (grant_cpu && starve != SMAX)
        starve <= starve + 4'd1;

      unique case (state)
        IDLE: begin
          unique case (1'b1)
            pend: begin
              owner          <= OWN_DL;
              pend           <= 1'b0;
              mem.o_MEM_WE   <= 1'b1;
              mem.o_MEM_ADDR <= w_addr;
              mem.o_MEM_DIN  <= w_data;
              mem.o_MEM_RQ   <= 1'b1;
              state          <= ISSUE;
            end
            grant_snd: begin
              owner          <= OWN_SND;
              mem.o_MEM_WE   <= 1'b0;
              mem.o_MEM_ADDR <= i_SND_ADDR;
              mem.o_MEM_RQ   <= 1'b1;
              state          <= ISSUE;
            end
            grant_cpu: begin
              owner          <= OWN_CPU;
              mem.o_MEM_WE   <= 1'b0;
              mem.o_MEM_ADDR <= i_CPU_ADDR;
              mem.o_MEM_RQ   <= 1'b1;
              state          <= ISSUE;
            end
            default: ;
          endcase
        end
        ISSUE: begin
          if (mem.i_MEM_ACK) begin
            mem.o_MEM_RQ <= 1'b0;
            state <= mem.i_MEM_RDY ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (mem.i_MEM_RDY)
            state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (mem_done) begin
        unique case (owner)
          OWN_CPU: begin
            o_CPU_DATA <= mem.i_MEM_DOUT;
            o_CPU_RDY  <= 1'b1;
          end
          OWN_SND: begin
            o_SND_DATA <= mem.i_MEM_DOUT;
            o_SND_RDY  <= 1'b1;
          end
          default: o_DL_WAIT <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bubsys_sdram_arbiter.sv
// Directed bench for bubsys_sdram_arbiter; the bench plays the
// SDRAM controller and all three clients.
module tb_bubsys_sdram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        dl_en;
  logic        dl_wr;
  logic [26:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;
  logic        cpu_rq;
  logic        snd_rq;
  logic [23:0] cpu_addr;
  logic [23:0] snd_addr;
  logic [15:0] cpu_data;
  logic [15:0] snd_data;
  logic        cpu_rdy;
  logic        snd_rdy;

  int checks = 0;
  int errors = 0;

  bubsys_sdram_arbiter_if #(.AW(24)) mem();

  bubsys_sdram_arbiter #(
    .AW(24),
    .STARVE_MAX(8)
  ) dut (
    .i_EMU_MCLK (clk),
    .i_EMU_RST_n(rst_n),
    .i_DL_EN    (dl_en),
    .i_DL_WR    (dl_wr),
    .i_DL_ADDR  (dl_addr),
    .i_DL_DATA  (dl_data),
    .o_DL_WAIT  (dl_wait),
    .i_CPU_RQ   (cpu_rq),
    .i_SND_RQ   (snd_rq),
    .i_CPU_ADDR (cpu_addr),
    .i_SND_ADDR (snd_addr),
    .o_CPU_DATA (cpu_data),
    .o_SND_DATA (snd_data),
    .o_CPU_RDY  (cpu_rdy),
    .o_SND_RDY  (snd_rdy),
    .mem        (mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Controller model: wait for a request, check it,
  // ack, then complete one cycle later.
  task automatic serve(input string tag,
                       input logic we,
                       input logic [23:0] addr,
                       input logic [15:0] din,
                       input logic [15:0] dout,
                       input bit dl_at_wait);
    int n;
    n = 0;
    while (mem.o_MEM_RQ !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " rq"}, 32'(mem.o_MEM_RQ), 32'd1);
    if (mem.o_MEM_RQ === 1'b1) begin
      chk({tag, " we"}, 32'(mem.o_MEM_WE), 32'(we));
      chk({tag, " addr"}, 32'(mem.o_MEM_ADDR),
          32'(addr));
      if (we)
        chk({tag, " din"}, 32'(mem.o_MEM_DIN),
            32'(din));
      mem.i_MEM_ACK = 1'b1;
      tick();
      mem.i_MEM_ACK = 1'b0;
      chk({tag, " rq drop"}, 32'(mem.o_MEM_RQ), 32'd0);
      if (dl_at_wait)
        dl_en = 1'b1;
      mem.i_MEM_RDY  = 1'b1;
      mem.i_MEM_DOUT = dout;
      tick();
      mem.i_MEM_RDY  = 1'b0;
      mem.i_MEM_DOUT = 16'h0000;
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    dl_en          = 1'b0;
    dl_wr          = 1'b0;
    dl_addr        = '0;
    dl_data        = '0;
    cpu_rq         = 1'b0;
    snd_rq         = 1'b0;
    cpu_addr       = '0;
    snd_addr       = '0;
    mem.i_MEM_ACK  = 1'b0;
    mem.i_MEM_RDY  = 1'b0;
    mem.i_MEM_DOUT = '0;
    repeat (3) tick();

    chk("rst rq", 32'(mem.o_MEM_RQ), 32'd0);
    chk("rst wait", 32'(dl_wait), 32'd0);
    chk("rst cpu rdy", 32'(cpu_rdy), 32'd0);
    chk("rst snd rdy", 32'(snd_rdy), 32'd0);
    chk("rst cpu data", 32'(cpu_data), 32'd0);
    chk("rst snd data", 32'(snd_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Two-byte download -> one word write
    dl_en   = 1'b1;
    dl_wr   = 1'b1;
    dl_addr = 27'd0;
    dl_data = 8'h11;
    tick();
    dl_addr = 27'd1;
    dl_data = 8'h22;
    tick();
    dl_wr = 1'b0;
    chk("dl wait up", 32'(dl_wait), 32'd1);
    serve("dl word", 1'b1, 24'd0, 16'h2211,
          16'h0000, 1'b0);
    chk("dl wait done", 32'(dl_wait), 32'd0);
    chk("dl no cpu rdy", 32'(cpu_rdy), 32'd0);

    // Odd-length download then flush
    dl_wr   = 1'b1;
    dl_addr = 27'd4;
    dl_data = 8'hAA;
    tick();
    dl_wr = 1'b0;
    dl_en = 1'b0;
    serve("flush", 1'b1, 24'd2, 16'h00AA,
          16'h0000, 1'b0);
    repeat (3) tick();
    chk("flush once", 32'(mem.o_MEM_RQ), 32'd0);

    // Simultaneous CPU/SND requests
    cpu_addr = 24'h000100;
    snd_addr = 24'h000100;
    cpu_rq   = 1'b1;
    snd_rq   = 1'b1;
    serve("prio cpu", 1'b0, 24'h000100, 16'h0,
          16'h1234, 1'b0);
    chk("prio cpu rdy", 32'(cpu_rdy), 32'd1);
    chk("prio cpu data", 32'(cpu_data), 32'h1234);
    chk("prio snd idle", 32'(snd_rdy), 32'd0);
    cpu_rq = 1'b0;
    serve("prio snd", 1'b0, 24'h000100, 16'h0,
          16'h5678, 1'b0);
    chk("prio snd rdy", 32'(snd_rdy), 32'd1);
    chk("prio snd data", 32'(snd_data), 32'h5678);
    chk("prio cpu hold", 32'(cpu_data), 32'h1234);
    snd_rq = 1'b0;
    tick();

    // Starvation guard
    cpu_addr = 24'h000200;
    snd_addr = 24'h000300;
    cpu_rq   = 1'b1;
    snd_rq   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      serve($sformatf("starve cpu%0d", i), 1'b0,
            24'h000200, 16'h0, 16'(16'hC000 + i),
            1'b0);
      chk($sformatf("starve cpu%0d data", i),
          32'(cpu_data), 32'(16'hC000 + i));
    end
    serve("starve snd", 1'b0, 24'h000300, 16'h0,
          16'h5AD0, 1'b0);
    chk("starve snd rdy", 32'(snd_rdy), 32'd1);
    chk("starve snd data", 32'(snd_data), 32'h5AD0);
    serve("starve resume", 1'b0, 24'h000200, 16'h0,
          16'hC0DE, 1'b0);
    chk("starve resume rdy", 32'(cpu_rdy), 32'd1);
    cpu_rq = 1'b0;
    snd_rq = 1'b0;
    tick();

    // Download starts while a CPU read is in flight
    cpu_addr = 24'h000400;
    cpu_rq   = 1'b1;
    serve("dlen rd", 1'b0, 24'h000400, 16'h0,
          16'hBEEF, 1'b1);
    chk("dlen rd rdy", 32'(cpu_rdy), 32'd1);
    chk("dlen rd data", 32'(cpu_data), 32'hBEEF);
    repeat (6) tick();
    chk("dlen no grant", 32'(mem.o_MEM_RQ), 32'd0);
    chk("dlen no rdy", 32'(cpu_rdy), 32'd0);
    dl_en = 1'b0;
    serve("dlen resume", 1'b0, 24'h000400, 16'h0,
          16'hFACE, 1'b0);
    chk("dlen resume data", 32'(cpu_data), 32'hFACE);
    cpu_rq = 1'b0;
    tick();

    // Reset mid-ISSUE
    cpu_addr = 24'h000500;
    cpu_rq   = 1'b1;
    tick();
    tick();
    chk("rst issue rq", 32'(mem.o_MEM_RQ), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst abort rq", 32'(mem.o_MEM_RQ), 32'd0);
    chk("rst abort cpu", 32'(cpu_rdy), 32'd0);
    chk("rst abort snd", 32'(snd_rdy), 32'd0);
    chk("rst abort data", 32'(cpu_data), 32'd0);
    tick();
    rst_n = 1'b1;
    serve("post rst", 1'b0, 24'h000500, 16'h0,
          16'h9ABC, 1'b0);
    chk("post rst rdy", 32'(cpu_rdy), 32'd1);
    chk("post rst data", 32'(cpu_data), 32'h9ABC);
    cpu_rq = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/bubsys_sdram_arbiter.md
# bubsys_sdram_arbiter

Single-port SDRAM access arbiter for the Bubble System emulator core, sitting between the SDRAM controller and its three clients. The clients are the HPS ROM download stream (ioctl), the main CPU ROM fetch port and the sound sample ROM fetch port (K5289/VLM). The block packs download bytes into 16-bit word writes and back-pressures the HPS via ioctl_wait. It grants reads by fixed priority, with a starvation guard for the sound port, and keeps exactly one SDRAM transaction outstanding.

## Interface
- AW, 24, SDRAM word address width
- STARVE_MAX, 8, consecutive CPU grants allowed while sound waits (1..15)

- i_EMU_MCLK  in  1  system clock (72 MHz domain)
- i_EMU_RST_n  in  1  asynchronous, active-low reset
- i_DL_EN  in  1  ROM download active (ioctl_download qualified by index)
- i_DL_WR  in  1  download byte strobe, one cycle
- i_DL_ADDR  in  27  download byte address
- i_DL_DATA  in  8  download byte
- o_DL_WAIT  out  1  ioctl_wait back-pressure
- i_CPU_RQ / i_SND_RQ  in  1  read request levels
- i_CPU_ADDR / i_SND_ADDR  in  AW  word addresses, held while RQ high
- o_CPU_DATA / o_SND_DATA  out  16  read data, held until next RDY to that port
- o_CPU_RDY / o_SND_RDY  out  1  one-cycle completion pulse
- o_MEM_RQ  out  1  request to controller, held until ack
- o_MEM_WE  out  1  1 = write
- o_MEM_ADDR  out  AW  word address
- o_MEM_DIN  out  16  write data {odd byte, even byte}
- i_MEM_ACK  in  1  controller accepted request (one cycle)
- i_MEM_RDY  in  1  transaction complete; i_MEM_DOUT valid this cycle
- i_MEM_DOUT  in  16  read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- Arbitration is evaluated in IDLE only, in this priority order:
  - pending download word write;
  - if i_DL_EN is low: SND when the starve counter equals STARVE_MAX, else CPU, else SND.
- While i_DL_EN is high, CPU and SND are never granted and their RDY outputs stay low. Any read already in flight completes normally.
- On grant, latch the owner, the address (word address = i_DL_ADDR[AW:1] for downloads), WE and DIN, then go to ISSUE.
- ISSUE: o_MEM_RQ=1. On i_MEM_ACK, drop o_MEM_RQ and go to WAIT.
- WAIT: on i_MEM_RDY, latch i_MEM_DOUT into the owner's data register (reads only) and go to DONE.
- DONE: pulse the owner's RDY (reads) or release o_DL_WAIT (writes), then return to IDLE.
- Requester rule: a requester deasserts RQ on the edge at which it samples RDY. IDLE re-samples RQ one cycle after DONE.
- Byte packing:
  - i_DL_WR with i_DL_ADDR[0]=0: store the byte in the low-byte latch and set the half-word flag. No SDRAM access.
  - i_DL_WR with i_DL_ADDR[0]=1: form {byte, latch}, set download-pending and clear the flag.
  - o_DL_WAIT rises the cycle after an odd-byte strobe and falls in DONE of that write.
- Flush: when i_DL_EN falls with the half-word flag set, issue a write of {8'h00, latch} to the latched address, then clear the flag.
- Starve counter (4 bit):
  - increments on each CPU grant while i_SND_RQ is high, saturating at STARVE_MAX;
  - clears on an SND grant or whenever i_SND_RQ is low.
- An even-byte strobe that arrives while a write is in flight is accepted into the latch. An odd-byte strobe while o_DL_WAIT is high is a protocol violation; the later strobe is ignored.

## Timing
- Reset: state IDLE; all outputs 0, including o_MEM_RQ, o_DL_WAIT, both RDY outputs and both data registers; latch, flag, pending and starve counter cleared.
- A reset assertion mid-transaction aborts it immediately. No RDY pulse is generated, and the controller must be reset together with this block.
- Read latency: RQ high at edge N (state IDLE) gives o_MEM_RQ=1 from N+1.
  - Ack at edge A gives WAIT from A+1; o_MEM_RQ is low from A+1.
  - i_MEM_RDY at edge R gives o_X_RDY=1 and valid data in cycle R+1.
  - Best case RQ to RDY is 3 cycles plus controller latency.
- Back-to-back: the next grant at the earliest is at the edge after DONE, so at most one transaction per 4 cycles plus controller latency.
- CPU and SND requests that rise in the same cycle are resolved by priority; the loser stays pending with no loss.
- i_MEM_ACK and i_MEM_RDY arriving in the same cycle in ISSUE: treat as ack plus completion and go directly to DONE.

## Test plan
- Download bytes 0x11@0, 0x22@1 -> one write: ADDR=0, DIN=16'h2211. o_DL_WAIT high from the cycle after the second strobe until DONE.
- Odd-length download 0xAA@4, then i_DL_EN falls -> flush write: ADDR=2, DIN=16'h00AA.
- CPU_RQ and SND_RQ rise together, both addresses 0x000100, controller returns 0x1234 -> CPU served first and sees RDY+data 0x1234; SND served next.
- CPU_RQ held continuously with SND_RQ high, STARVE_MAX=8 -> 8 CPU grants, then exactly one SND grant, then CPU resumes.
- i_DL_EN rises while a CPU read is in WAIT -> the read completes with an RDY pulse; a new CPU_RQ gets no grant until i_DL_EN falls.
- i_EMU_RST_n pulled low during ISSUE -> o_MEM_RQ=0 and both RDY outputs 0 immediately. After release, a fresh CPU read completes normally.
